cache_controller: RTL and testbench



---
 rtl/cache_pkg.sv | 26 ++
 rtl/cache_backing_mem.sv | 33 +++
 rtl/cache_controller.sv | 166 ++++++++++++++++
 tb/tb_cache_controller.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache controller.
package cache_pkg;

    localparam int LINES     = 8;
    localparam int FILL_LAT  = 2;
    localparam int TAG_W     = 4;
    localparam int IDX_W     = 3;
    localparam int ADDR_W    = TAG_W + IDX_W;
    localparam int DATA_W    = 8;
    localparam int MEM_DEPTH = 1 << ADDR_W;
    localparam int FILL_CNT_W = 2;
    localparam logic [DATA_W-1:0] RESET_PAT = 8'h5A;

    // Encodings double as the state code reported on uo_out[7:4].
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        FILL   = 2'd2,
        RESP   = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] backing_init(input logic [ADDR_W-1:0] a);
        return {1'b0, a} ^ RESET_PAT;
    endfunction

endpackage

// File: rtl/cache_backing_mem.sv
// 128x8 backing store: combinational read, synchronous write, reset to a per-address pattern.
module cache_backing_mem
    import cache_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic              we,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [MEM_DEPTH-1:0][DATA_W-1:0] mem_vec;

    // Per-entry registers so every byte can return to its pattern on reset.
    genvar gi;
    generate
        for (gi = 0; gi < MEM_DEPTH; gi++) begin : gen_entry
            logic [DATA_W-1:0] byte_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    byte_reg <= backing_init(ADDR_W'(gi));
                end else if (we && addr == ADDR_W'(gi)) begin
                    byte_reg <= wdata;
                end
            end
            assign mem_vec[gi] = byte_reg;
        end
    endgenerate

    assign rdata = mem_vec[addr];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, write-allocate cache in front of a 128x8 backing store.
module cache_controller
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_t state_reg, state_next;

    logic                  req_we_reg;
    logic [ADDR_W-1:0]     req_addr_reg;
    logic [DATA_W-1:0]     req_wdata_reg;
    logic [FILL_CNT_W-1:0] fill_cnt_reg;
    logic                  hit_reg, miss_reg;
    logic [DATA_W-1:0]     rdata_reg, uio_out_reg, uio_oe_reg;

    logic [LINES-1:0]              valid_vec;
    logic [LINES-1:0][TAG_W-1:0]   tag_vec;
    logic [LINES-1:0][DATA_W-1:0]  data_vec;

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic              lookup_hit;
    logic [DATA_W-1:0] mem_rdata, line_data;

    logic capture, lookup, mem_we, line_we, line_src_mem;
    logic rdata_from_line, rdata_from_mem, fill_inc, fill_clr, finish;

    assign req_tag    = req_addr_reg[ADDR_W-1:IDX_W];
    assign req_idx    = req_addr_reg[IDX_W-1:0];
    assign lookup_hit = valid_vec[req_idx] && (tag_vec[req_idx] == req_tag);
    assign line_data  = line_src_mem ? mem_rdata : req_wdata_reg;

    cache_backing_mem u_mem (
        .clk   (clk),
        .rst   (rst),
        .addr  (req_addr_reg),
        .we    (mem_we),
        .wdata (req_wdata_reg),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_reg <= IDLE;
        else     state_reg <= state_next;
    end

    always_comb begin
        state_next      = state_reg;
        capture         = 1'b0;
        lookup          = 1'b0;
        mem_we          = 1'b0;
        line_we         = 1'b0;
        line_src_mem    = 1'b0;
        rdata_from_line = 1'b0;
        rdata_from_mem  = 1'b0;
        fill_inc        = 1'b0;
        fill_clr        = 1'b0;
        finish          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ena) begin
                    capture    = 1'b1;
                    state_next = LOOKUP;
                end
            end
            LOOKUP: begin
                lookup = 1'b1;
                if (req_we_reg) begin
                    mem_we     = 1'b1;
                    line_we    = 1'b1;
                    state_next = RESP;
                end else if (lookup_hit) begin
                    rdata_from_line = 1'b1;
                    state_next      = RESP;
                end else begin
                    fill_clr   = 1'b1;
                    state_next = FILL;
                end
            end
            FILL: begin
                if (fill_cnt_reg == FILL_CNT_W'(FILL_LAT - 1)) begin
                    line_we        = 1'b1;
                    line_src_mem   = 1'b1;
                    rdata_from_mem = 1'b1;
                    state_next     = RESP;
                end else begin
                    fill_inc = 1'b1;
                end
            end
            RESP: begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_we_reg    <= 1'b0;
            req_addr_reg  <= '0;
            req_wdata_reg <= '0;
            fill_cnt_reg  <= '0;
            hit_reg       <= 1'b0;
            miss_reg      <= 1'b0;
            rdata_reg     <= '0;
            uio_out_reg   <= '0;
            uio_oe_reg    <= '0;
        end else begin
            if (capture) begin
                req_we_reg    <= ui_in[7];
                req_addr_reg  <= ui_in[ADDR_W-1:0];
                req_wdata_reg <= uio_in;
            end
            if (fill_clr)      fill_cnt_reg <= '0;
            else if (fill_inc) fill_cnt_reg <= fill_cnt_reg + 1'b1;
            if (lookup) begin
                hit_reg  <= lookup_hit;
                miss_reg <= !lookup_hit;
            end
            if (rdata_from_line)     rdata_reg <= data_vec[req_idx];
            else if (rdata_from_mem) rdata_reg <= mem_rdata;
            // Writes leave the last read byte visible; only the enable drops.
            if (finish) begin
                if (!req_we_reg) uio_out_reg <= rdata_reg;
                uio_oe_reg <= req_we_reg ? 8'h00 : 8'hFF;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : gen_line
            logic              valid_reg;
            logic [TAG_W-1:0]  tag_reg;
            logic [DATA_W-1:0] data_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    valid_reg <= 1'b0;
                    tag_reg   <= '0;
                    data_reg  <= '0;
                end else if (line_we && req_idx == IDX_W'(gi)) begin
                    valid_reg <= 1'b1;
                    tag_reg   <= req_tag;
                    data_reg  <= line_data;
                end
            end
            assign valid_vec[gi] = valid_reg;
            assign tag_vec[gi]   = tag_reg;
            assign data_vec[gi]  = data_reg;
        end
    endgenerate

    assign uo_out  = {2'b00, state_reg, (state_reg != IDLE), (state_reg == RESP), miss_reg, hit_reg};
    assign uio_out = uio_out_reg;
    assign uio_oe  = uio_oe_reg;

endmodule

// File: tb/tb_cache_controller.sv
// Directed-vector scoreboard bench for cache_controller: driver queues expectations, monitor checks on done.
module tb_cache_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;

    cache_controller dut (
        .clk     (clk),
        .rst     (rst),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    typedef struct {
        int         done_cyc;
        bit         hit;
        bit         miss;
        logic [7:0] uio;
        logic [7:0] oe;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   pend = 1'b0;

    // Monitor: done is checked on the cycle it shows; read data/enable one cycle later.
    always @(negedge clk) begin
        if (pend) begin
            chk("uio_out", uio_out, cur.uio);
            chk("uio_oe", uio_oe, cur.oe);
            pend = 1'b0;
        end
        if (!rst) begin
            if (uo_out[2]) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_done", uo_out[2], 0);
                end else begin
                    cur = exp_q.pop_front();
                    chk("done_cycle", cyc, cur.done_cyc);
                    chk("hit", uo_out[0], cur.hit);
                    chk("miss", uo_out[1], cur.miss);
                    chk("busy", uo_out[3], 1);
                    chk("state_code", uo_out[7:4], 3);
                    $display("txn done at cycle %0d: uo_out=0x%02h", cyc, uo_out);
                    pend = 1'b1;
                end
            end else if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
                chk("done_timeout", uo_out[2], 1);
                void'(exp_q.pop_front());
            end
        end
    end

    logic [7:0] last_rd = 8'h00;

    // exp_hit/exp_rd are for the first pass; later passes of a held request must hit.
    task automatic do_req(input bit we, input logic [6:0] addr, input logic [7:0] wdata,
                          input bit exp_hit, input logic [7:0] exp_rd, input int passes);
        int   c;
        int   lat;
        bit   h;
        exp_t e;
        lat = 0;
        @(negedge clk);
        ui_in  = {we, addr};
        uio_in = wdata;
        ena    = 1'b1;
        for (int p = 0; p < passes; p++) begin
            if (p == 0) @(posedge clk);
            else repeat (lat) @(posedge clk);
            #1;
            c   = cyc;
            h   = (p == 0) ? exp_hit : 1'b1;
            lat = (we || h) ? 3 : 5;
            if (!we) last_rd = exp_rd;
            e.done_cyc = c + lat - 2;
            e.hit      = h;
            e.miss     = !h;
            e.uio      = last_rd;
            e.oe       = we ? 8'h00 : 8'hFF;
            exp_q.push_back(e);
            $display("txn issue cycle %0d: we=%0d addr=0x%02h wdata=0x%02h exp_hit=%0d exp_rd=0x%02h",
                     c, we, addr, wdata, h, last_rd);
            if (p == passes - 1) begin
                ena    = 1'b0;
                ui_in  = 8'($urandom);
                uio_in = 8'($urandom);
            end
        end
        repeat (lat) @(posedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_uo_out", uo_out, 8'h00);
        chk("reset_uio_out", uio_out, 8'h00);
        chk("reset_uio_oe", uio_oe, 8'h00);
        rst = 1'b0;

        // we  addr   wdata  hit  rdata  passes
        do_req(1, 7'h04, 8'h3C, 0, 8'h00, 1);   // write miss allocates
        do_req(0, 7'h04, 8'h00, 1, 8'h3C, 1);   // read hit of written byte
        do_req(0, 7'h08, 8'h00, 0, 8'h52, 2);   // cold miss then held re-issue hits
        do_req(0, 7'h04, 8'h00, 1, 8'h3C, 1);
        do_req(0, 7'h0C, 8'h00, 0, 8'h56, 1);   // conflict evicts tag 0 at index 4
        do_req(0, 7'h04, 8'h00, 0, 8'h3C, 1);   // refetch shows write-through
        do_req(1, 7'h21, 8'h77, 0, 8'h00, 2);   // held write: miss then hit
        do_req(0, 7'h21, 8'h00, 1, 8'h77, 1);

        // Reset while a read miss sits in FILL.
        @(negedge clk);
        ui_in = 8'h10;
        ena   = 1'b1;
        @(posedge clk);
        #1 ena = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_uo_out", uo_out, 8'h00);
        chk("midrst_uio_out", uio_out, 8'h00);
        chk("midrst_uio_oe", uio_oe, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        last_rd = 8'h00;

        do_req(0, 7'h04, 8'h00, 0, 8'h5E, 1);   // line and backing store both reset
        do_req(0, 7'h7F, 8'h00, 0, 8'h25, 1);   // top address

        // ena low while idle: nothing captured, outputs hold.
        @(negedge clk);
        ena   = 1'b0;
        ui_in = 8'h85;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_uo_out", uo_out, 8'h02);
            chk("idle_uio_out", uio_out, 8'h25);
            chk("idle_uio_oe", uio_oe, 8'hFF);
        end

        repeat (6) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
